// File: rtl/mult_accum_stage.sv
// Packet dot-product accumulator fed by the signed 8x8 multiplier pipeline.
// Define MULT_ACCUM_SATURATE_EN to saturate results instead of wrapping them.
module mult_accum_stage #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned MAX_TERMS = 64,
  localparam int unsigned ACC_W    = IN_W + $clog2(MAX_TERMS),
  localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;

  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        count_next;
  logic signed [OUT_W-1:0] result;
  logic                    accept;
  logic                    emit;

`ifdef MULT_ACCUM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  assign in_ready = (state != FULL) && !clear;
  assign accept   = in_valid && in_ready;

  // Next sum/count for an accepted beat; IDLE starts a fresh packet.
  always_comb begin
    acc_next   = (state == ACCUM) ? acc + ACC_W'(in_data) : ACC_W'(in_data);
    count_next = (state == ACCUM) ? count + CNT_W'(1) : CNT_W'(1);
    emit       = accept && (in_last || (count_next == CNT_W'(MAX_TERMS)));
`ifdef MULT_ACCUM_SATURATE_EN
    if (acc_next > SAT_MAX) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (acc_next < SAT_MIN) begin
      result = SAT_MIN[OUT_W-1:0];
    end else begin
      result = acc_next[OUT_W-1:0];
    end
`else
    result = acc_next[OUT_W-1:0];
`endif
  end

  // Held result in FULL is immune to clear; only the consumer handshake frees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_count   <= '0;
      out_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
          end else if (emit) begin
            state       <= FULL;
            acc         <= '0;
            count       <= '0;
            out_valid   <= 1'b1;
            out_data    <= result;
            out_count   <= count_next;
            out_overrun <= !in_last;
          end else if (accept) begin
            state <= ACCUM;
            acc   <= acc_next;
            count <= count_next;
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accum_stage.sv
// Directed self-checking bench for mult_accum_stage (default and MAX_TERMS=4 instances).
module tb_mult_accum_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef MULT_ACCUM_SATURATE_EN
  localparam logic signed [15:0] EXP_POS = 16'sh7FFF;
  localparam logic signed [15:0] EXP_NEG = 16'sh8000;
`else
  localparam logic signed [15:0] EXP_POS = 16'sh0000;
  localparam logic signed [15:0] EXP_NEG = 16'sh0000;
`endif

  // Instance A: default parameters
  logic              clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic signed [15:0] in_data = '0;
  logic              in_ready, out_valid, out_overrun;
  logic signed [15:0] out_data;
  logic [6:0]        out_count;

  mult_accum_stage dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_overrun(out_overrun)
  );

  // Instance B: MAX_TERMS=4 for forced emit
  logic              b_clear = 1'b0, b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic signed [15:0] b_in_data = '0;
  logic              b_in_ready, b_out_valid, b_out_overrun;
  logic signed [15:0] b_out_data;
  logic [2:0]        b_out_count;

  mult_accum_stage #(.MAX_TERMS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_overrun(b_out_overrun)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Present one beat to A for a single edge; returns at edge+1.
  task automatic beat(input logic signed [15:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic beat_b(input logic signed [15:0] d, input logic l);
    b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic test_reset;
    #23;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_count !== 7'd0 || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got v=%b d=%0d c=%0d o=%b want 0 0 0 0", out_valid, out_data, out_count, out_overrun);
    end
    checks++;
    if (in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got in_ready=%b b_out_valid=%b want 1 0", in_ready, b_out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    beat(16'sd100, 1'b0);
    beat(-16'sd50, 1'b0);
    beat(16'sd25, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd75 || out_count !== 7'd3 || out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got v=%b d=%0d c=%0d o=%b want 1 75 3 0", out_valid, out_data, out_count, out_overrun);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_full got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single;
    beat(-16'sd300, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'shFED4 || out_count !== 7'd1) begin
      errors++;
      $display("FAIL single got v=%b d=%h c=%0d want 1 fed4 1", out_valid, out_data, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) beat(16'sd16384, i == 3);
    checks++;
    if (out_valid !== 1'b1 || out_data !== EXP_POS || out_count !== 7'd4) begin
      errors++;
      $display("FAIL overflow_pos got v=%b d=%0d c=%0d want 1 %0d 4", out_valid, out_data, out_count, EXP_POS);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) beat(-16'sd16384, i == 3);
    checks++;
    if (out_valid !== 1'b1 || out_data !== EXP_NEG || out_count !== 7'd4) begin
      errors++;
      $display("FAIL overflow_neg got v=%b d=%0d c=%0d want 1 %0d 4", out_valid, out_data, out_count, EXP_NEG);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_terms;
    b_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat_b(16'sd1, 1'b0);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 16'sd4 || b_out_count !== 3'd4 || b_out_overrun !== 1'b1) begin
      errors++;
      $display("FAIL max_first got v=%b d=%0d c=%0d o=%b want 1 4 4 1", b_out_valid, b_out_data, b_out_count, b_out_overrun);
    end
    checks++;
    if (b_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL max_ready_full got %b want 0", b_in_ready);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_release got %b want 0", b_out_valid);
    end
    beat_b(16'sd1, 1'b1);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 16'sd1 || b_out_count !== 3'd1 || b_out_overrun !== 1'b0) begin
      errors++;
      $display("FAIL max_second got v=%b d=%0d c=%0d o=%b want 1 1 1 0", b_out_valid, b_out_data, b_out_count, b_out_overrun);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(16'sd100, 1'b0);
    beat(-16'sd50, 1'b0);
    beat(16'sd25, 1'b1);
    in_valid = 1'b1; in_data = 16'sd123; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'sd75 || out_count !== 7'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%0d c=%0d rdy=%b want 1 75 3 0", i, out_valid, out_data, out_count, in_ready);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got %b want 0", out_valid);
    end
    beat(16'sd5, 1'b1);
    checks++;
    if (out_data !== 16'sd5 || out_count !== 7'd1) begin
      errors++;
      $display("FAIL bp_not_consumed got d=%0d c=%0d want 5 1", out_data, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_clear;
    out_ready = 1'b1;
    beat(16'sd7, 1'b0);
    beat(16'sd8, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_count !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid_accum got v=%b c=%0d want 0 0", out_valid, out_count);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(16'sd5, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd5 || out_count !== 7'd1) begin
      errors++;
      $display("FAIL rst_new_packet got v=%b d=%0d c=%0d want 1 5 1", out_valid, out_data, out_count);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_count !== 7'd0) begin
      errors++;
      $display("FAIL rst_full got v=%b d=%0d c=%0d want 0 0 0", out_valid, out_data, out_count);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    beat(16'sd7, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'sd9; in_last = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    beat(16'sd2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd2 || out_count !== 7'd1) begin
      errors++;
      $display("FAIL clear_result got v=%b d=%0d c=%0d want 1 2 1", out_valid, out_data, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_in_full;
    out_ready = 1'b0;
    beat(16'sd11, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd11) begin
      errors++;
      $display("FAIL clear_full got v=%b d=%0d want 1 11", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_overflow;
    test_max_terms;
    test_backpressure;
    test_reset_clear;
    test_clear_in_full;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_accum_stage.md
Name: mult_accum_stage

Overview:
- Downstream consumer of the 2-stage signed 8x8 DSP multiplier pipeline.
- Accumulates a packet of signed 16-bit products, terminated by a last flag, into a wide accumulator.
- Emits one truncated or saturated dot-product result per packet over a valid/ready handshake.
- Targets ECP5 fabric or the ALU54A post-adder; the behaviour below is target-independent.

Parameters:
IN_W, 16, signed product width from multiplier stage
OUT_W, 16, signed result width
MAX_TERMS, 64, max products per packet before forced emit (>=2)
ACC_W (localparam), IN_W+$clog2(MAX_TERMS), accumulator width; never overflows within MAX_TERMS
CNT_W (localparam), $clog2(MAX_TERMS+1), term counter width

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
clear  in  1  sync abandon of partial packet
in_valid  in  1  product valid
in_ready  out  1  stage can accept product
in_data  in  IN_W  signed product
in_last  in  1  final product of packet
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  signed result
out_count  out  CNT_W  number of terms in result
out_overrun  out  1  result was force-emitted at MAX_TERMS without in_last

Behaviour:
- Reset: rst_n low asynchronously clears state to IDLE, acc=0, count=0, out_valid=0, out_data=0, out_count=0, out_overrun=0. Reset mid-packet discards the partial sum and any held result.
- States:
  - IDLE: no terms accumulated.
  - ACCUM: at least 1 term accumulated.
  - FULL: result held on outputs.
- in_ready = (state != FULL) && !clear. Combinational only from state and clear. Beat accepted on in_valid && in_ready.
- Accept in IDLE: acc <= sext(in_data), count <= 1.
- Accept in ACCUM: acc <= acc + sext(in_data), count <= count+1.
- Emit condition: accepted beat has in_last=1, or the new count == MAX_TERMS.
  - On emit, the next cycle: state=FULL, out_valid=1, out_data=result(acc_next), out_count=count_next, out_overrun = !in_last.
  - acc and count are cleared.
  - Latency: last beat accepted at edge N, out_valid high after edge N.
- FULL: outputs held stable until out_valid && out_ready. Then out_valid=0 and state=IDLE next cycle. One bubble cycle per packet; no input accepted while FULL.
- clear=1 in IDLE/ACCUM: acc=0, count=0, state=IDLE; a simultaneous in_valid beat is not accepted.
- clear=1 in FULL: ignored; the held result is not dropped.
- Result mapping: acc[OUT_W-1:0] two's-complement wrap (default).
- out_data, out_count and out_overrun change only on the emit edge or reset.

Optional Feature:
- Macro: MULT_ACCUM_SATURATE_EN.
- Defined: the result saturates to the signed OUT_W range.
  - acc > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1.
  - acc < -2^(OUT_W-1) gives -2^(OUT_W-1).
  - Otherwise acc[OUT_W-1:0].
- Undefined: wrap truncation as above.
- No port or latency change in either case.

Test Plan:
1. Products 100, -50, 25 (last on 25), out_ready=1 -> one cycle after the 3rd beat: out_valid=1, out_data=75, out_count=3, out_overrun=0; in_ready=0 that cycle, 1 next.
2. Single beat -300 with in_last=1 -> out_data=-300 (0xFED4), out_count=1.
3. Four beats of 16384, last on 4th -> sum 65536: without macro out_data=0; with MULT_ACCUM_SATURATE_EN out_data=32767. Four beats of -16384 -> without macro 0; with macro -32768.
4. MAX_TERMS=4, five beats of 1 with in_last only on the 5th:
   - First result: out_data=4, out_count=4, out_overrun=1.
   - After out_ready, second result: out_data=1, out_count=1, out_overrun=0.
5. Backpressure: result 75 held with out_ready=0 for 3 cycles -> out_valid, out_data, out_count stable; in_ready=0; in_valid beats are not consumed. Then out_ready=1 for 1 cycle -> out_valid=0 next.
6. Reset and clear mid-packet:
   - Accept 7, 8; assert rst_n=0 mid-cycle -> out_valid=0 immediately. New packet 5 (last) -> 5.
   - Accept 7; clear=1 with in_valid=1 and data 9 (not accepted). Then 2 (last) -> out_data=2, out_count=1.
